wshb_mire_writer: RTL and testbench

- Wishbone master that paints a test pattern ("mire") into the SDRAM framebuffer, upstream of the VGA framebuffer reader.
- Both masters share the SDRAM through the Wishbone arbiter. This block periodically releases cyc so the reader's FIFO never starves.
- One frame is written per start pulse: HDISP*VDISP 32-bit words, in raster order from address 0.

---
 rtl/wshb_mire_writer.sv | 117 +++++++++++
 tb/tb_wshb_mire_writer.sv | 104 ++++++++++
 2 files changed

// File: rtl/wshb_mire_writer.sv
// wshb_mire_writer: Wishbone master painting a test pattern into the framebuffer, yielding the bus between bursts.
// Optional MIRE_ANIM_EN: frame counter animates the pattern and frames restart automatically.
module wshb_mire_writer #(
   parameter int HDISP = 800,
   parameter int VDISP = 480,
   parameter int BURST = 64,
   parameter int GAP   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        wshb_cyc,
   output logic        wshb_stb,
   output logic        wshb_we,
   output logic [31:0] wshb_adr,
   output logic [31:0] wshb_dat_ms,
   output logic [3:0]  wshb_sel,
   output logic [2:0]  wshb_cti,
   output logic [1:0]  wshb_bte,
   input  logic        wshb_ack
);
   localparam int XW = $clog2(HDISP);
   localparam int YW = $clog2(VDISP);
   localparam int BW = $clog2(BURST + 1);
   localparam int GW = $clog2(GAP + 1);
   typedef enum logic [1:0] {IDLE, WRITE, YIELD} state_t;
   state_t state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [GW-1:0] gap_q, gap_d;
   logic done_q, ack, x_last, y_last, last, burst_end, restart, wr, grid;
   logic [31:0] xe, ye, pix;
   logic [7:0] r, g;
`ifdef MIRE_ANIM_EN
   logic [7:0] frame_q;
   assign restart = done_q;
   assign r = xe[7:0] + frame_q;
   assign g = ye[7:0] + frame_q;
`else
   assign restart = 1'b0;
   assign r = xe[7:0];
   assign g = ye[7:0];
`endif
   assign wr        = state_q == WRITE;
   assign ack       = wr && wshb_ack;
   assign x_last    = x_q == XW'(HDISP - 1);
   assign y_last    = y_q == YW'(VDISP - 1);
   assign last      = ack && x_last && y_last;
   assign burst_end = burst_q == BW'(BURST - 1);
   assign xe        = 32'(x_q);
   assign ye        = 32'(y_q);
   assign pix       = ye * 32'(HDISP) + xe;
   assign grid      = xe[3:0] == 4'd0 || ye[3:0] == 4'd0;
   assign wshb_cyc    = wr;
   assign wshb_stb    = wr;
   assign wshb_we     = wr;
   assign wshb_adr    = wr ? pix << 2 : '0;
   assign wshb_dat_ms = !wr ? '0 : grid ? 32'h00FF_FFFF : {8'h00, r, g, 8'h00};
   assign wshb_sel    = 4'b1111;
   assign wshb_cti    = 3'b000;
   assign wshb_bte    = 2'b00;
   assign busy        = state_q != IDLE;
   assign done        = done_q;
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      burst_d = burst_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: if (start || restart) begin
            state_d = WRITE;
            x_d     = '0;
            y_d     = '0;
            burst_d = '0;
         end
         WRITE: if (ack) begin
            x_d     = x_last ? '0 : x_q + XW'(1);
            y_d     = !x_last ? y_q : y_last ? '0 : y_q + YW'(1);
            burst_d = (burst_end || last) ? '0 : burst_q + BW'(1);
            gap_d   = '0;
            state_d = last ? IDLE : burst_end ? YIELD : WRITE;
         end
         YIELD: begin
            gap_d   = gap_q + GW'(1);
            state_d = gap_q == GW'(GAP - 1) ? WRITE : YIELD;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         burst_q <= '0;
         gap_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         burst_q <= burst_d;
         gap_q   <= gap_d;
         done_q  <= last;
      end
   end
`ifdef MIRE_ANIM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_q <= '0;
      else if (last) frame_q <= frame_q + 8'd1;
   end
`endif
endmodule

// File: tb/tb_wshb_mire_writer.sv
// tb_wshb_mire_writer: randomized-ack directed bench for the mire writer against a raster-order pixel model.
module tb_wshb_mire_writer;
   localparam int H = 8, V = 2, B = 4, G = 3, TOT = H * V;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, ack = 1'b0;
   logic busy, done, cyc, stb, we;
   logic [31:0] adr, dat;
   logic [3:0] sel;
   logic [2:0] cti;
   logic [1:0] bte;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   wshb_mire_writer #(.HDISP(H), .VDISP(V), .BURST(B), .GAP(G)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .wshb_cyc(cyc), .wshb_stb(stb), .wshb_we(we), .wshb_adr(adr),
      .wshb_dat_ms(dat), .wshb_sel(sel), .wshb_cti(cti), .wshb_bte(bte),
      .wshb_ack(ack)
   );
   function automatic logic [31:0] pat(input int x, input int y);
      return (x % 16 == 0 || y % 16 == 0) ? 32'h00FF_FFFF : 32'(((x % 256) << 16) | ((y % 256) << 8));
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // Pixel n is expected on the bus until acked; a burst boundary opens a G-cycle gap unless it is the last pixel.
   task automatic run_frame(input int dmin, input int dmax, input bit poke);
      int n = 0, gap = 0, wc = 0, d, cnt = 0;
      d = $urandom_range(dmax, dmin);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      while (n < TOT && cnt < 1000) begin
         chk("busy", busy, 1);
         chk("cyc", cyc, gap == 0);
         chk("stb", stb, gap == 0);
         chk("we", we, gap == 0);
         if (gap == 0) begin
            chk("adr", adr, 4 * n);
            chk("dat", dat, pat(n % H, n / H));
            ack = wc == d;
            if (ack) begin
               wc = 0;
               n++;
               d = $urandom_range(dmax, dmin);
               if (n < TOT && n % B == 0) gap = G;
            end else wc++;
         end else begin
            ack = 1'($urandom_range(1, 0));
            gap--;
         end
         start = poke && $urandom_range(1, 0) == 1;
         cnt++;
         @(negedge clk);
      end
      ack = 1'b0;
      start = 1'b0;
      chk("acks", n, TOT);
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("cyc_end", cyc, 0);
      if (dmax == 0) chk("busy_len", cnt, TOT + (TOT - 1) / B * G);
      repeat (3) begin
         @(negedge clk);
         chk("done_off", done, 0);
         chk("idle_cyc", cyc, 0);
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_cyc", cyc, 0);
      chk("rst_stb", stb, 0);
      chk("rst_adr", adr, 0);
      chk("rst_dat", dat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("sel", sel, 4'hF);
      chk("cti", cti, 0);
      chk("bte", bte, 0);
      rst = 1'b0;
      run_frame(0, 0, 1'b0);
      run_frame(3, 3, 1'b0);
      run_frame(0, 4, 1'b1);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      ack = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_adr", adr, 12);
      #1 rst = 1'b1;
      #1;
      chk("abort_cyc", cyc, 0);
      chk("abort_stb", stb, 0);
      chk("abort_adr", adr, 0);
      chk("abort_busy", busy, 0);
      ack = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", cyc, 0);
      run_frame(0, 2, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
